// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and frame constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO using extra-MSB read/write pointers to tell full from empty.
module uart_sync_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          i_push,
  input  logic [7:0]                    i_wdata,
  input  logic                          i_pop,
  output logic [7:0]                    o_rdata,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_push;
  logic        w_pop;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_level = r_wptr - r_rptr;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; only the pointers define which entries are valid.
  always_ff @(posedge HCLK) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO; define UART_TX_PARITY_EN to add a parity bit
// (parity_odd port, PARITY state, 11-bit frames).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PRESC_W    = 16
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic                         en,
  input  logic [PRESC_W-1:0]           prescaler,
  input  logic [7:0]                   wdata,
  input  logic                         wvalid,
  output logic                         wready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  level
`ifdef UART_TX_PARITY_EN
  ,
  input  logic                         parity_odd
`endif
);

  state_t             r_state;
  state_t             w_state_next;
  logic [7:0]         r_shift;
  logic [7:0]         w_rdata;
  logic [PRESC_W-1:0] r_bit_len;
  logic [PRESC_W-1:0] r_cnt;
  logic [2:0]         r_bit_idx;
  logic               r_tx;
  logic               w_tx_next;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_bit_end;
  logic               w_can_start;
  logic               w_advance;
`ifdef UART_TX_PARITY_EN
  logic               r_parity;
`endif

  uart_sync_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .i_push  (wvalid),
    .i_wdata (wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign w_bit_end   = (r_cnt == '0);
  assign w_can_start = en && !w_empty;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_len <= '0;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      // The bit time is latched per frame so prescaler changes apply at the next frame.
      if (w_pop) begin
        r_shift   <= w_rdata;
        r_bit_len <= prescaler;
        r_cnt     <= prescaler;
      end else if (w_advance) begin
        r_cnt <= r_bit_len;
        if (w_state_next == ST_DATA) r_shift <= r_shift >> 1;
      end else if (r_state != ST_IDLE) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_advance) r_bit_idx <= (w_state_next == r_state) ? r_bit_idx + 1'b1 : '0;
`ifdef UART_TX_PARITY_EN
      if (w_pop) r_parity <= ^w_rdata ^ parity_odd;
`endif
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves a latch.
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_can_start) w_state_next = ST_START;
      ST_START: if (w_bit_end) w_state_next = ST_DATA;
      ST_DATA: begin
        if (w_bit_end && r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (w_bit_end) w_state_next = ST_STOP;
`endif
      ST_STOP: begin
        if (w_bit_end && r_bit_idx == 3'(STOP_BITS - 1))
          w_state_next = w_can_start ? ST_START : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A frame is popped whenever START is entered, from IDLE or straight out of STOP.
  always_comb begin
    w_advance = (r_state == ST_IDLE) ? w_can_start : w_bit_end;
    w_pop     = w_advance && (w_state_next == ST_START);
    w_tx_next = r_tx;
    if (w_advance) begin
      case (w_state_next)
        ST_START:  w_tx_next = 1'b0;
        ST_DATA:   w_tx_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
        ST_PARITY: w_tx_next = r_parity;
`endif
        default:   w_tx_next = 1'b1;
      endcase
    end
  end

  assign tx     = r_tx;
  assign busy   = (r_state != ST_IDLE);
  assign wready = !w_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a serial monitor decodes tx and compares frames
// against a scoreboard queue filled when bytes are written.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int DEPTH = 8;
  localparam int PW    = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          en = 1'b0;
  logic [PW-1:0] prescaler = 16'd15;
  logic [7:0]    wdata = 8'h00;
  logic          wvalid = 1'b0;
  logic          wready;
  logic          tx;
  logic          busy;
  logic [3:0]    level;
`ifdef UART_TX_PARITY_EN
  logic          parity_odd = 1'b0;
  logic          last_par = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [8:0] sb_q[$];

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .PRESC_W(PW)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .en        (en),
    .prescaler (prescaler),
    .wdata     (wdata),
    .wvalid    (wvalid),
    .wready    (wready),
    .tx        (tx),
    .busy      (busy),
    .level     (level)
`ifdef UART_TX_PARITY_EN
    ,
    .parity_odd(parity_odd)
`endif
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected frame as transmitted, LSB first: start, data, [parity], stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b ^ parity_odd, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  task automatic sb_push(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    sb_q.push_back({^b ^ parity_odd, b});
`else
    sb_q.push_back({1'b0, b});
`endif
  endtask

  task automatic write_byte(input logic [7:0] b);
    wdata  = b;
    wvalid = 1'b1;
    @(posedge HCLK); #1;
    wvalid = 1'b0;
    sb_push(b);
  endtask

  task automatic wait_idle(input int max, input string tag);
    int t = 0;
    while (busy && t < max) begin
      @(posedge HCLK); #1;
      t++;
    end
    check(tag, busy, 0);
  endtask

  task automatic count_busy(input int exp, input string tag);
    int n = 0;
    int t = 0;
    bit seen = 0;
    while (t < 6000) begin
      @(posedge HCLK); #1;
      t++;
      if (busy) begin
        n++;
        seen = 1;
      end else if (seen) begin
        break;
      end
    end
    check({tag, "_ended"}, (t < 6000), 1);
    check(tag, n, exp);
  endtask

  task automatic count_tx_low(input int cycles, input string tag);
    int lows = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge HCLK); #1;
      if (tx !== 1'b1) lows++;
    end
    check(tag, lows, 0);
  endtask

  // Serial monitor: detects a start bit, samples each bit mid-way, scores the frame.
  initial begin
    logic [FRAME_BITS-1:0] bits;
    logic [8:0] rx;
    logic [8:0] e;
    int p;
    int idx;
    int target;
    bit abort;
    forever begin
      @(negedge HCLK);
      if (HRESETn === 1'b1 && tx === 1'b0) begin
        p = int'(prescaler);
        idx = 0;
        abort = 0;
        for (int j = 0; j < FRAME_BITS; j++) begin
          target = j * (p + 1) + p / 2;
          while (idx < target && !abort) begin
            @(negedge HCLK);
            idx++;
            if (!HRESETn) abort = 1;
          end
          if (abort) break;
          bits[j] = tx;
        end
        if (!abort) begin
          check("rx_start_bit", bits[0], 0);
          check("rx_stop_bit", bits[FRAME_BITS-1], 1);
`ifdef UART_TX_PARITY_EN
          rx = {bits[9], bits[8:1]};
          last_par = bits[9];
`else
          rx = {1'b0, bits[8:1]};
`endif
          check("rx_frame_pending", (sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("rx_frame", rx, e);
          end
          $display("terminal: '%c' (0x%02h)", bits[8:1], bits[8:1]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] fb;
    int bad;
    int m_level;

    // Reset state.
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_wready", wready, 1);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // 0x41 at 16 clocks per bit, checked cycle by cycle.
    prescaler = 16'd15;
    en = 1'b1;
    write_byte(8'h41);
    check("t1_tx_before_start", tx, 1);
    check("t1_level_after_push", level, 1);
    fb = frame_of(8'h41);
    @(posedge HCLK); #1;
    check("t1_start_latency", tx, 0);
    bad = (busy !== 1'b1) ? 1 : 0;
    for (int c = 1; c < FRAME_BITS * 16; c++) begin
      @(posedge HCLK); #1;
      if (tx !== fb[c / 16] || busy !== 1'b1) bad++;
    end
    check("t1_bit_cycles", bad, 0);
    @(posedge HCLK); #1;
    check("t1_busy_end", busy, 0);

    // Fill with en low: 9 back-to-back writes, the 9th dropped.
    en = 1'b0;
    prescaler = 16'd3;
    m_level = 0;
    wvalid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wdata = 8'h30 + 8'(i);
      @(posedge HCLK); #1;
      if (m_level < DEPTH) begin
        sb_push(wdata);
        m_level++;
      end
      check("t2_level", level, m_level);
      check("t2_wready", wready, (m_level < DEPTH));
    end
    wvalid = 1'b0;
    check("t2_full_level", level, DEPTH);
    en = 1'b1;
    count_busy(DEPTH * FRAME_BITS * 4, "t2_back_to_back_busy");
    check("t2_drained", level, 0);

    // One cycle per bit.
    prescaler = 16'd0;
    write_byte(8'hA5);
    fb = frame_of(8'hA5);
    for (int c = 0; c < FRAME_BITS; c++) begin
      @(posedge HCLK); #1;
      check($sformatf("t3_tx_bit%0d", c), tx, fb[c]);
      check($sformatf("t3_busy%0d", c), busy, 1);
    end
    @(posedge HCLK); #1;
    check("t3_busy_fall", busy, 0);

    // Reset during data bit 3 of 0xFF.
    prescaler = 16'd15;
    write_byte(8'hFF);
    repeat (16 * 4 + 8) @(posedge HCLK);
    #1;
    check("t4_mid_frame_busy", busy, 1);
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    check("t4_rst_tx", tx, 1);
    check("t4_rst_level", level, 0);
    check("t4_rst_busy", busy, 0);
    sb_q.delete();
    HRESETn = 1'b1;
    count_tx_low(200, "t4_no_residual_tx");
    check("t4_idle_after", busy, 0);

    // en dropped mid-frame with a second byte queued.
    prescaler = 16'd3;
    wdata = 8'h5A;
    wvalid = 1'b1;
    @(posedge HCLK); #1;
    sb_push(8'h5A);
    wdata = 8'hC3;
    @(posedge HCLK); #1;
    wvalid = 1'b0;
    sb_push(8'hC3);
    repeat (8) @(posedge HCLK);
    #1;
    en = 1'b0;
    wait_idle(200, "t5_frame_completes");
    check("t5_level_held", level, 1);
    count_tx_low(50, "t5_tx_held_high");
    check("t5_level_still", level, 1);
    en = 1'b1;
    @(posedge HCLK); #1;
    check("t5_resume_busy", busy, 1);
    wait_idle(200, "t5_second_done");
    check("t5_level_empty", level, 0);

`ifdef UART_TX_PARITY_EN
    // Parity bit for 0x07: even -> 1, odd -> 0.
    parity_odd = 1'b0;
    write_byte(8'h07);
    count_busy(11 * 4, "t6_even_frame_len");
    check("t6_even_parity", last_par, 1);
    parity_odd = 1'b1;
    write_byte(8'h07);
    count_busy(11 * 4, "t6_odd_frame_len");
    check("t6_odd_parity", last_par, 0);
`endif

    repeat (10) @(posedge HCLK);
    check("sb_all_received", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
